// File: rtl/multi_cycle_pkg.sv
// Shared opcodes, FSM states and ALU operations for the multi-cycle core.
// MULTI_CYCLE_HALT_EN adds the S_HALT state.
package multi_cycle_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_NDU  = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_JAL  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
`ifdef MULTI_CYCLE_HALT_EN
        S_WB     = 3'd4,
        S_HALT   = 3'd5
`else
        S_WB     = 3'd4
`endif
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_NAND = 2'd2
    } alu_op_t;

endpackage

// File: rtl/multi_cycle_alu.sv
// Combinational add/sub/nand datapath ALU with a zero flag.
module multi_cycle_alu
    import multi_cycle_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    always_comb begin
        case (op)
            ALU_SUB:  y = a - b;
            ALU_NAND: y = ~(a & b);
            default:  y = a + b;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/multi_cycle_processor.sv
// Multi-cycle 16-bit-ISA CPU: FETCH/DECODE/EXEC/MEM/WB over one shared ALU.
// Define MULTI_CYCLE_HALT_EN to make opcode 1111 a sticky HALT with a `halted` output.
module multi_cycle_processor
    import multi_cycle_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned IMEM_DEPTH = 16,
    parameter int unsigned DMEM_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [15:0]                   prog_data,
    input  logic [$clog2(DMEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_W-1:0]             dbg_data,
    output logic [15:0]                   pc,
    output logic [15:0]                   instr,
    output logic                          retire,
`ifdef MULTI_CYCLE_HALT_EN
    output logic                          halted,
`endif
    output logic [2:0]                    state
);

    localparam int unsigned IA = $clog2(IMEM_DEPTH);
    localparam int unsigned DA = $clog2(DMEM_DEPTH);

    state_t            state_q, state_d;
    logic [IA-1:0]     pc_q, pc_d;   // word index; byte pc is {pc_q, 1'b0}
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] a_q, b_q, alu_out_q, mdr_q;

    logic [DATA_W-1:0] regs [8];
    logic [15:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    logic [3:0] op;
    logic [2:0] ra, rb, rc;
    assign op = instr_q[15:12];
    assign ra = instr_q[11:9];
    assign rb = instr_q[8:6];
    assign rc = instr_q[5:3];

    logic [DATA_W-1:0] imm6_ext;
    assign imm6_ext = {{(DATA_W-6){instr_q[5]}}, instr_q[5:0]};

    // Byte offsets folded to word offsets: drop bit 0, sign-extend/truncate to IA bits.
    logic [IA-1:0] off6, off9;
    for (genvar g = 0; g < IA; g++) begin : g_off
        localparam int unsigned S6 = (g < 5) ? g + 1 : 5;
        localparam int unsigned S9 = (g < 8) ? g + 1 : 8;
        assign off6[g] = instr_q[S6];
        assign off9[g] = instr_q[S9];
    end

    logic [IA-1:0] pc_inc, pc_br, pc_jal;
    assign pc_inc = pc_q + IA'(1);
    assign pc_br  = pc_q + off6;
    assign pc_jal = pc_q + off9;

    logic [DATA_W-1:0] link;
    always_comb begin
        link         = '0;
        link[IA:0]   = {pc_inc, 1'b0};
    end

    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_b, alu_y;
    logic              alu_zero;

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = b_q;
        case (op)
            OP_NDU:       alu_op = ALU_NAND;
            OP_BEQ:       alu_op = ALU_SUB;
            OP_LW, OP_SW: alu_b  = imm6_ext;
            default:      ;
        endcase
    end

    multi_cycle_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op   (alu_op),
        .a    (a_q),
        .b    (alu_b),
        .y    (alu_y),
        .zero (alu_zero)
    );

    logic              instr_we, reg_we, dmem_we, retire_raw;
    logic [2:0]        reg_waddr;
    logic [DATA_W-1:0] reg_wdata;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_we   = 1'b0;
        reg_we     = 1'b0;
        reg_waddr  = rc;
        reg_wdata  = alu_out_q;
        dmem_we    = 1'b0;
        retire_raw = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    instr_we = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_NDU: state_d = S_WB;
                    OP_LW, OP_SW:   state_d = S_MEM;
                    OP_BEQ: begin
                        pc_d       = alu_zero ? pc_br : pc_inc;
                        retire_raw = 1'b1;
                        state_d    = S_FETCH;
                    end
                    OP_JAL: begin
                        reg_we     = 1'b1;
                        reg_waddr  = ra;
                        reg_wdata  = link;
                        pc_d       = pc_jal;
                        retire_raw = 1'b1;
                        state_d    = S_FETCH;
                    end
`ifdef MULTI_CYCLE_HALT_EN
                    OP_HALT: begin
                        retire_raw = 1'b1;
                        state_d    = S_HALT;
                    end
`endif
                    default: begin
                        pc_d       = pc_inc;
                        retire_raw = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (op == OP_SW) begin
                    dmem_we    = 1'b1;
                    pc_d       = pc_inc;
                    retire_raw = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_waddr  = (op == OP_LW) ? rb : rc;
                reg_wdata  = (op == OP_LW) ? mdr_q : alu_out_q;
                pc_d       = pc_inc;
                retire_raw = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MULTI_CYCLE_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            instr_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (instr_we) begin
                instr_q <= imem[pc_q];
            end
            if (state_q == S_DECODE) begin
                a_q <= regs[ra];
                b_q <= regs[rb];
            end
            if (state_q == S_EXEC) begin
                alu_out_q <= alu_y;
            end
            if (state_q == S_MEM) begin
                mdr_q <= dmem[alu_out_q[DA-1:0]];
            end
            if (reg_we) begin
                regs[reg_waddr] <= reg_wdata;
            end
        end
    end

    // Memories are never cleared; a store in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (prog_we && !run) begin
            imem[prog_addr] <= prog_data;
        end
        if (dmem_we && !rst) begin
            dmem[alu_out_q[DA-1:0]] <= b_q;
        end
    end

    always_comb begin
        pc         = '0;
        pc[IA:0]   = {pc_q, 1'b0};
    end

    assign dbg_data = dmem[dbg_addr];
    assign instr    = instr_q;
    assign retire   = retire_raw & ~rst;
    assign state    = state_q;
`ifdef MULTI_CYCLE_HALT_EN
    assign halted   = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_multi_cycle_processor.sv
// Directed + randomized bench for multi_cycle_processor against an ISA-level model.
module tb_multi_cycle_processor;
    import multi_cycle_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data, pc, instr;
    logic        retire;
    logic [2:0]  state;
`ifdef MULTI_CYCLE_HALT_EN
    logic        halted;
`endif

    always #5 clk = ~clk;

    multi_cycle_processor #(
        .DATA_W     (16),
        .IMEM_DEPTH (16),
        .DMEM_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .pc        (pc),
        .instr     (instr),
        .retire    (retire),
`ifdef MULTI_CYCLE_HALT_EN
        .halted    (halted),
`endif
        .state     (state)
    );

    int checks = 0;
    int errors = 0;

    // ISA-level reference state
    logic [15:0] m_imem [16];
    logic [15:0] m_dmem [16];
    logic [15:0] m_reg  [8];
    int          m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Executes one instruction at m_pc; returns its cycle count.
    function automatic int m_step();
        logic [15:0] w, a, b;
        int i6, i9, nxt, lat;
        w   = m_imem[m_pc / 2];
        a   = m_reg[w[11:9]];
        b   = m_reg[w[8:6]];
        i6  = int'($signed(w[5:0]));
        i9  = int'($signed(w[8:0]));
        nxt = m_pc + 2;
        lat = 3;
        case (w[15:12])
            4'h0: begin m_reg[w[5:3]] = a + b;                          lat = 4; end
            4'h2: begin m_reg[w[5:3]] = ~(a & b);                       lat = 4; end
            4'h4: begin m_reg[w[8:6]] = m_dmem[(int'(a) + i6) & 15];    lat = 5; end
            4'h5: begin m_dmem[(int'(a) + i6) & 15] = b;                lat = 4; end
            4'hC: if (a == b) nxt = m_pc + i6;
            4'h8: begin m_reg[w[11:9]] = 16'((m_pc + 2) & 30); nxt = m_pc + i9; end
`ifdef MULTI_CYCLE_HALT_EN
            4'hF: nxt = m_pc;
`endif
            default: ;
        endcase
        m_pc = nxt & 30;
        return lat;
    endfunction

    function automatic logic [3:0] rand_op();
        logic [3:0] o;
        case ($urandom_range(0, 7))
            0: o = 4'h0;
            1: o = 4'h2;
            2: o = 4'h4;
            3: o = 4'h5;
            4: o = 4'hC;
            5: o = 4'h8;
            default: o = 4'($urandom_range(0, 15));
        endcase
`ifdef MULTI_CYCLE_HALT_EN
        if (o == 4'hF) o = 4'h3;
`endif
        return o;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        run = 1'b0; prog_we = 1'b0; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_pc = 0;
    endtask

    task automatic load_prog();
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 16; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = m_imem[i];
            @(negedge clk);
        end
        prog_we = 1'b0;
    endtask

    task automatic check_dmem(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            check($sformatf("%s dmem[%0d]", tag, i), dbg_data, m_dmem[i]);
        end
    endtask

    task automatic wait_state(input state_t s, input string tag);
        int n = 0;
        while (state !== s && n < 20) begin @(negedge clk); n++; end
        check({tag, " reach state"}, state, s);
    endtask

    // Loads m_imem, resets, and runs n instructions checking pc/instr/latency each retire.
    task automatic run_prog(input int n, input string tag);
        int cyc, lat;
        load_prog();
        do_reset();
        run = 1'b1;
        for (int k = 0; k < n; k++) begin
            check({tag, " pc"}, pc, m_pc);
            cyc = 1;
            while (retire !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
            check({tag, " instr"}, instr, m_imem[m_pc / 2]);
            lat = m_step();
            check({tag, " latency"}, cyc, lat);
            @(negedge clk);
        end
        run = 1'b0;
        check({tag, " final pc"}, pc, m_pc);
        check({tag, " final state"}, state, S_FETCH);
        @(negedge clk);
        check_dmem(tag);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset pc", pc, 16'h0000);
        check("reset instr", instr, 16'h0000);
        check("reset state", state, S_FETCH);
        check("reset retire", retire, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("hold pc with run=0", pc, 16'h0000);
        check("hold state with run=0", state, S_FETCH);

        // Clear dmem through 16 stores of r0.
        for (int i = 0; i < 16; i++) m_imem[i] = 16'h5000 | 16'(i);
        run_prog(16, "init");

        // Reset during MEM of a store must drop the store.
        for (int i = 0; i < 16; i++) m_imem[i] = 16'h3000;
        m_imem[0] = 16'h2008;  // NDU r1 = ~(r0&r0)
        m_imem[1] = 16'h5042;  // SW  r1 -> dmem[r0+2]
        load_prog();
        do_reset();
        run = 1'b1;
        wait_state(S_MEM, "rst-sw");
        rst = 1'b1;
        @(negedge clk);
        check("rst-sw pc", pc, 16'h0000);
        check("rst-sw state", state, S_FETCH);
        check("rst-sw instr", instr, 16'h0000);
        dbg_addr = 4'd2;
        #1;
        check("rst-sw dmem[2]", dbg_data, 16'h0000);
        rst = 1'b0;
        run = 1'b0;

        // JAL r5,+10 at pc=4, then store r5 at pc=14.
        for (int i = 0; i < 16; i++) m_imem[i] = 16'h3000;
        m_imem[2] = 16'h8A0A;
        m_imem[7] = 16'h5145;
        run_prog(4, "jal");
        check("jal pc", pc, 16'd16);
        dbg_addr = 4'd5;
        #1;
        check("jal link r5", dbg_data, 16'd6);

        // BEQ at pc=6, imm -4: taken first pass (->2), not taken second (->8).
        for (int i = 0; i < 16; i++) m_imem[i] = 16'h3000;
        m_imem[1] = 16'h2488;
        m_imem[2] = 16'h2010;
        m_imem[3] = 16'hC2BC;
        run_prog(7, "beq");
        check("beq pc", pc, 16'd8);

        // Run drops mid-ADD; prog_we ignored while running, accepted when stopped.
        for (int i = 0; i < 16; i++) m_imem[i] = 16'h3000;
        m_imem[0] = 16'h0298;
        load_prog();
        do_reset();
        run = 1'b1;
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'h5ABC;
        @(negedge clk);
        prog_we = 1'b0;
        wait_state(S_EXEC, "rundrop");
        run = 1'b0;
        @(negedge clk);
        check("rundrop retire", retire, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rundrop hold state", state, S_FETCH);
            check("rundrop hold pc", pc, 16'd2);
        end
        run = 1'b1;
        @(negedge clk);
        check("prog_we ignored", instr, 16'h3000);
        run = 1'b0;
        wait_state(S_FETCH, "rundrop nop");
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h3ABC;
        @(negedge clk);
        prog_we = 1'b0;
        do_reset();
        run = 1'b1;
        @(negedge clk);
        check("prog_we accepted", instr, 16'h3ABC);
        run = 1'b0;
        wait_state(S_FETCH, "accepted nop");

        // Random programs.
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 16; i++) m_imem[i] = {rand_op(), 12'($urandom)};
            run_prog(40, $sformatf("rand%0d", p));
        end

`ifdef MULTI_CYCLE_HALT_EN
        for (int i = 0; i < 16; i++) m_imem[i] = 16'h3000;
        m_imem[1] = 16'hF000;
        load_prog();
        do_reset();
        run = 1'b1;
        repeat (6) @(negedge clk);
        check("halt state", state, S_HALT);
        for (int i = 0; i < 20; i++) begin
            check("halted", halted, 1'b1);
            check("halt pc", pc, 16'd2);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("halt cleared", halted, 1'b0);
        check("halt reset state", state, S_FETCH);
        rst = 1'b0;
        run = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
